// File: rtl/imem_prog.sv
// imem_prog: run-time loadable instruction memory with a registered valid/ready fetch path.
// Per-word valid bits make unwritten words read as NOOP; out-of-range accesses are flagged.
module imem_prog #(
    parameter int WORD_W = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_W = 32,
    parameter logic [WORD_W-1:0] NOOP_WORD = '0,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    output logic              prog_err,
    output logic [IDX_W:0]    loaded_count,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] PC,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] Instruction,
    output logic              rsp_err,
    output logic              rsp_empty
);
    typedef enum logic {RUN, LOAD} state_t;
    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);
    state_t            state;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  wvalid;
    logic [IDX_W-1:0]  widx, ridx;
    logic              wr, wr_ok, pc_ok, acc;
    // Mode follows prog_en directly, so a write and an accepted fetch never share a cycle.
    always_comb begin
        state = prog_en ? LOAD : RUN;
        req_ready = (state == RUN);
        wr = (state == LOAD) & prog_we;
        widx = prog_addr[IDX_W-1:0];
        ridx = PC[IDX_W-1:0];
        wr_ok = (prog_addr >> IDX_W) == '0;
        pc_ok = (PC >> IDX_W) == '0;
        acc = req_valid & req_ready;
    end
    always_ff @(posedge clk)
        if (wr && wr_ok) mem[widx] <= prog_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wvalid <= '0;
            loaded_count <= '0;
            prog_err <= 1'b0;
        end else begin
            prog_err <= wr & ~wr_ok;
            if (wr && wr_ok) begin
                wvalid[widx] <= 1'b1;
                if (!wvalid[widx] && loaded_count != FULL) loaded_count <= loaded_count + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            Instruction <= NOOP_WORD;
            rsp_err <= 1'b0;
            rsp_empty <= 1'b0;
        end else begin
            rsp_valid <= acc;
            if (acc) begin
                Instruction <= (pc_ok && wvalid[ridx]) ? mem[ridx] : NOOP_WORD;
                rsp_err <= ~pc_ok;
                rsp_empty <= pc_ok & ~wvalid[ridx];
            end
        end
    end
endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: scenario tasks plus randomized traffic against an array-based memory model.
module tb_imem_prog;
    logic        clk = 1'b0, reset = 1'b1;
    logic        prog_en = 1'b0, prog_we = 1'b0, req_valid = 1'b0;
    logic [31:0] prog_addr = '0, prog_data = '0, PC = '0;
    logic        prog_err, req_ready, rsp_valid, rsp_err, rsp_empty;
    logic [6:0]  loaded_count;
    logic [31:0] Instruction;
    int          checks = 0, failures = 0;
    logic [31:0] m_mem [64];
    bit          m_val [64];
    logic [31:0] e_instr = '0;
    bit          e_err = 0, e_empty = 0;

    imem_prog dut (
        .clk(clk), .reset(reset), .prog_en(prog_en), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err),
        .loaded_count(loaded_count), .req_valid(req_valid), .req_ready(req_ready),
        .PC(PC), .rsp_valid(rsp_valid), .Instruction(Instruction),
        .rsp_err(rsp_err), .rsp_empty(rsp_empty)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int c = 0;
        foreach (m_val[i]) c += int'(m_val[i]);
        return c;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        if (a < 64) begin
            m_mem[a[5:0]] = d;
            m_val[a[5:0]] = 1;
        end
    endtask

    task automatic m_fetch(input logic [31:0] pc);
        if (pc >= 64) begin
            e_instr = '0; e_err = 1; e_empty = 0;
        end else if (!m_val[pc[5:0]]) begin
            e_instr = '0; e_err = 0; e_empty = 1;
        end else begin
            e_instr = m_mem[pc[5:0]]; e_err = 0; e_empty = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [31:0] a, input logic [31:0] d);
        prog_en = 1; prog_we = 1; prog_addr = a; prog_data = d; req_valid = 0;
        m_write(a, d);
    endtask

    task automatic set_fetch(input logic [31:0] pc);
        prog_en = 0; prog_we = 0; req_valid = 1; PC = pc;
        m_fetch(pc);
    endtask

    task automatic set_idle();
        prog_en = 0; prog_we = 0; req_valid = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        foreach (m_val[i]) m_val[i] = 0;
        e_instr = '0; e_err = 0; e_empty = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({rsp_valid, rsp_err, rsp_empty, prog_err, loaded_count, Instruction, req_ready} !== {4'b0, 7'd0, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b err=%b empty=%b perr=%b cnt=%0d instr=%h ready=%b, want 0 0 0 0 0 00000000 1",
                     rsp_valid, rsp_err, rsp_empty, prog_err, loaded_count, Instruction, req_ready);
        end
        tick();
        reset = 0;
        set_write(0, 32'hA5A5_0001);
        tick();
        set_fetch(0);
        tick();
        set_idle();
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefetch: rsp_valid=%b want 1", rsp_valid);
        end
        reset = 1;
        #1;
        checks++;
        if ({rsp_valid, loaded_count, Instruction} !== {1'b0, 7'd0, 32'h0}) begin
            failures++;
            $display("FAIL reset_async: valid=%b cnt=%0d instr=%h want 0 0 00000000", rsp_valid, loaded_count, Instruction);
        end
        foreach (m_val[i]) m_val[i] = 0;
        e_instr = '0; e_err = 0; e_empty = 0;
        #1 reset = 0;
        set_fetch(0);
        tick();
        set_idle();
        checks++;
        if ({rsp_valid, rsp_empty, Instruction} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_wvalid_cleared: valid=%b empty=%b instr=%h want 1 1 00000000", rsp_valid, rsp_empty, Instruction);
        end
        tick();
    endtask

    task automatic test_load_fetch();
        logic [31:0] w [3];
        w = '{32'h1110_0193, 32'hE500_0004, 32'h4800_0000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_write(i, w[i]);
            tick();
            checks++;
            if (loaded_count !== 7'(i + 1)) begin
                failures++;
                $display("FAIL load_count[%0d]: got %0d want %0d", i, loaded_count, i + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_fetch(i); else set_idle();
            tick();
            checks++;
            if (rsp_valid !== (i < 3)) begin
                failures++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", i, rsp_valid, i < 3);
            end
            if (i < 3) begin
                checks++;
                if ({Instruction, rsp_err, rsp_empty} !== {w[i], 2'b00}) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: got %h err=%b empty=%b want %h 0 0", i, Instruction, rsp_err, rsp_empty, w[i]);
                end
            end
        end
        checks++;
        if (Instruction !== w[2]) begin
            failures++;
            $display("FAIL hold_instr: got %h want %h", Instruction, w[2]);
        end
    endtask

    task automatic test_overwrite();
        set_write(1, 32'hDEAD_BEEF);
        tick();
        checks++;
        if ({loaded_count, prog_err} !== {7'd3, 1'b0}) begin
            failures++;
            $display("FAIL overwrite_count: cnt=%0d perr=%b want 3 0", loaded_count, prog_err);
        end
        set_write(64, 32'h1234_5678);
        tick();
        checks++;
        if ({loaded_count, prog_err} !== {7'd3, 1'b1}) begin
            failures++;
            $display("FAIL oor_write: cnt=%0d perr=%b want 3 1", loaded_count, prog_err);
        end
        set_fetch(1);
        tick();
        set_idle();
        checks++;
        if ({prog_err, rsp_valid, Instruction} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL overwrite_fetch: perr=%b valid=%b instr=%h want 0 1 deadbeef", prog_err, rsp_valid, Instruction);
        end
        tick();
    endtask

    task automatic test_fetch_edge();
        logic [31:0] pcs [3];
        pcs = '{32'd5, 32'd64, 32'hFFFF_FFFF};
        set_write(63, 32'hCAFE_F00D);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_fetch(pcs[i]);
            tick();
            checks++;
            if ({rsp_valid, Instruction, rsp_err, rsp_empty} !== {1'b1, e_instr, e_err, e_empty}) begin
                failures++;
                $display("FAIL edge_fetch pc=%h: valid=%b instr=%h err=%b empty=%b want 1 %h %b %b",
                         pcs[i], rsp_valid, Instruction, rsp_err, rsp_empty, e_instr, e_err, e_empty);
            end
        end
        set_idle();
        tick();
        checks++;
        if ({rsp_valid, rsp_err, Instruction} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL edge_hold: valid=%b err=%b instr=%h want 0 1 00000000", rsp_valid, rsp_err, Instruction);
        end
    endtask

    task automatic test_block();
        prog_en = 1; prog_we = 0; req_valid = 1; PC = 0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL block_ready: got %b want 0", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL block_valid[%0d]: got %b want 0", i, rsp_valid);
            end
        end
        set_fetch(2);
        tick();
        prog_en = 1;
        checks++;
        if ({rsp_valid, Instruction, rsp_empty} !== {1'b1, e_instr, 1'b0}) begin
            failures++;
            $display("FAIL block_inflight: valid=%b instr=%h empty=%b want 1 %h 0", rsp_valid, Instruction, rsp_empty, e_instr);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL block_after: valid=%b want 0", rsp_valid);
        end
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            set_write(i, $urandom);
            tick();
        end
        checks++;
        if (loaded_count !== 7'd64) begin
            failures++;
            $display("FAIL sat_full: got %0d want 64", loaded_count);
        end
        set_write(0, 32'h0BAD_F00D);
        tick();
        set_idle();
        checks++;
        if (loaded_count !== 7'd64) begin
            failures++;
            $display("FAIL sat_rewrite: got %0d want 64", loaded_count);
        end
    endtask

    task automatic test_random();
        bit ev, ep;
        logic [31:0] a;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 79);
                prog_en = 1; prog_we = 1'($urandom_range(0, 1)); prog_addr = a; prog_data = $urandom;
                req_valid = 1'($urandom_range(0, 1)); PC = $urandom_range(0, 79);
                ev = 0; ep = prog_we && a >= 64;
                if (prog_we) m_write(a, prog_data);
            end else begin
                prog_en = 0; prog_we = 1'($urandom_range(0, 1)); prog_addr = $urandom_range(0, 79); prog_data = $urandom;
                req_valid = 1'($urandom_range(0, 1));
                PC = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 79));
                ev = req_valid; ep = 0;
                if (req_valid) m_fetch(PC);
            end
            tick();
            checks++;
            if ({rsp_valid, prog_err, loaded_count, Instruction, rsp_err, rsp_empty} !==
                {ev, ep, 7'(m_count()), e_instr, e_err, e_empty}) begin
                failures++;
                $display("FAIL rand[%0d]: valid=%b perr=%b cnt=%0d instr=%h err=%b empty=%b want %b %b %0d %h %b %b",
                         n, rsp_valid, prog_err, loaded_count, Instruction, rsp_err, rsp_empty,
                         ev, ep, m_count(), e_instr, e_err, e_empty);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_overwrite();
        test_fetch_edge();
        test_block();
        test_saturation();
        do_reset();
        test_random();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
